// File: rtl/mac_requant_packer.sv
// rtl/mac_requant_packer.sv - int8 requantizer and lane packer for MAC accumulator streams
//
// Takes 32-bit signed accumulators from the MAC result stream. Each one is
// multiplied by CFG_SCALE, rounded and right-shifted by CFG_SHIFT, offset by
// CFG_ZERO_POINT and saturated to int8. LANES results are packed into one
// output word, with lane 0 in the low byte. An element carrying TLAST closes
// the word early and emits it with a partial TKEEP.
//
// Optional build macro: REQUANT_RELU_EN clamps negative shifted results to 0
// before the zero-point add. Pipeline latency does not change.
//
// Ports:
//   ACLK, ARESET            clock; synchronous active-high reset
//   SD_AXIS_T*              accumulator input stream (TDATA, TVALID, TLAST, TREADY)
//   CFG_SCALE/SHIFT/ZERO_PT quasi-static requant configuration
//   MO_AXIS_T*              packed int8 output stream (TDATA, TKEEP, TVALID, TLAST, TREADY)
module mac_requant_packer #(
    parameter int LANES   = 4,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          SD_AXIS_TDATA,
    input  logic                 SD_AXIS_TVALID,
    input  logic                 SD_AXIS_TLAST,
    output logic                 SD_AXIS_TREADY,
    input  logic [SCALE_W-1:0]   CFG_SCALE,
    input  logic [SHIFT_W-1:0]   CFG_SHIFT,
    input  logic [7:0]           CFG_ZERO_POINT,
    output logic [8*LANES-1:0]   MO_AXIS_TDATA,
    output logic [LANES-1:0]     MO_AXIS_TKEEP,
    output logic                 MO_AXIS_TVALID,
    output logic                 MO_AXIS_TLAST,
    input  logic                 MO_AXIS_TREADY
);
    localparam int P_W  = 32 + SCALE_W + 1;
    localparam int S_W  = P_W + 1;
    localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic signed [S_W-1:0] SAT_MAX = 127;
    localparam logic signed [S_W-1:0] SAT_MIN = -128;

    // One stall signal for the whole pipe: everything moves only when the
    // output register is empty or being drained this cycle.
    logic en;
    logic accept;
    assign en             = !MO_AXIS_TVALID || MO_AXIS_TREADY;
    assign SD_AXIS_TREADY = en && !ARESET;
    assign accept         = SD_AXIS_TVALID && SD_AXIS_TREADY;

    // Stage 1: exact product of the accumulator and the zero-extended scale.
    logic signed [P_W-1:0] acc_ext;
    logic signed [P_W-1:0] scale_ext;
    logic signed [P_W-1:0] s1_prod;
    logic                  s1_valid;
    logic                  s1_last;

    assign acc_ext   = P_W'($signed(SD_AXIS_TDATA));
    assign scale_ext = $signed(P_W'(CFG_SCALE));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= acc_ext * scale_ext;
                s1_last <= SD_AXIS_TLAST;
            end
        end
    end

    // Stage 2: round half toward +inf, shift, zero point, saturate.
    // One extra bit of headroom keeps the rounding add from overflowing.
    logic signed [S_W-1:0] round_term;
    logic signed [S_W-1:0] shifted;
    logic signed [S_W-1:0] offset_val;
    logic [7:0]            sat_val;

    always_comb begin
        round_term = '0;
        if (CFG_SHIFT != '0) begin
            round_term = S_W'(1) << (CFG_SHIFT - SHIFT_W'(1));
        end
        shifted = (S_W'(s1_prod) + round_term) >>> CFG_SHIFT;
`ifdef REQUANT_RELU_EN
        if (shifted < 0) begin
            shifted = '0;
        end
`endif
        offset_val = shifted + S_W'($signed(CFG_ZERO_POINT));
        if (offset_val > SAT_MAX) begin
            sat_val = 8'h7F;
        end else if (offset_val < SAT_MIN) begin
            sat_val = 8'h80;
        end else begin
            sat_val = offset_val[7:0];
        end
    end

    logic       s2_valid;
    logic [7:0] s2_data;
    logic       s2_last;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_val;
                s2_last <= s1_last;
            end
        end
    end

    // Stage 3: the packing buffer collects lanes. A completed word moves into
    // the output register in one step, so the buffer is immediately free for
    // the next element.
    logic [8*LANES-1:0] pack_data;
    logic [LANES-1:0]   pack_keep;
    logic [LC_W-1:0]    lane_cnt;
    logic [8*LANES-1:0] next_data;
    logic [LANES-1:0]   next_keep;
    logic               word_done;

    always_comb begin
        next_data = pack_data | ((8*LANES)'(s2_data) << (8 * lane_cnt));
        next_keep = pack_keep | (LANES'(1) << lane_cnt);
        word_done = (lane_cnt == LC_W'(LANES - 1)) || s2_last;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pack_data      <= '0;
            pack_keep      <= '0;
            lane_cnt       <= '0;
            MO_AXIS_TDATA  <= '0;
            MO_AXIS_TKEEP  <= '0;
            MO_AXIS_TVALID <= 1'b0;
            MO_AXIS_TLAST  <= 1'b0;
        end else if (en) begin
            MO_AXIS_TVALID <= 1'b0;
            if (s2_valid) begin
                if (word_done) begin
                    MO_AXIS_TDATA  <= next_data;
                    MO_AXIS_TKEEP  <= next_keep;
                    MO_AXIS_TLAST  <= s2_last;
                    MO_AXIS_TVALID <= 1'b1;
                    pack_data      <= '0;
                    pack_keep      <= '0;
                    lane_cnt       <= '0;
                end else begin
                    pack_data <= next_data;
                    pack_keep <= next_keep;
                    lane_cnt  <= lane_cnt + LC_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_requant_packer.sv
// tb/tb_mac_requant_packer.sv - self-checking bench for mac_requant_packer
module tb_mac_requant_packer;
    localparam int LANES = 4;

    logic                ACLK = 1'b0;
    logic                ARESET;
    logic [31:0]         SD_AXIS_TDATA;
    logic                SD_AXIS_TVALID;
    logic                SD_AXIS_TLAST;
    logic                SD_AXIS_TREADY;
    logic [15:0]         CFG_SCALE;
    logic [4:0]          CFG_SHIFT;
    logic [7:0]          CFG_ZERO_POINT;
    logic [8*LANES-1:0]  MO_AXIS_TDATA;
    logic [LANES-1:0]    MO_AXIS_TKEEP;
    logic                MO_AXIS_TVALID;
    logic                MO_AXIS_TLAST;
    logic                MO_AXIS_TREADY;

    mac_requant_packer #(.LANES(LANES), .SCALE_W(16), .SHIFT_W(5)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .SD_AXIS_TDATA(SD_AXIS_TDATA), .SD_AXIS_TVALID(SD_AXIS_TVALID),
        .SD_AXIS_TLAST(SD_AXIS_TLAST), .SD_AXIS_TREADY(SD_AXIS_TREADY),
        .CFG_SCALE(CFG_SCALE), .CFG_SHIFT(CFG_SHIFT), .CFG_ZERO_POINT(CFG_ZERO_POINT),
        .MO_AXIS_TDATA(MO_AXIS_TDATA), .MO_AXIS_TKEEP(MO_AXIS_TKEEP),
        .MO_AXIS_TVALID(MO_AXIS_TVALID), .MO_AXIS_TLAST(MO_AXIS_TLAST),
        .MO_AXIS_TREADY(MO_AXIS_TREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [8*LANES-1:0] data;
        logic [LANES-1:0]   keep;
        logic               last;
    } word_t;

    word_t exp_q[$];
    logic [7:0] pend[$];
    int total = 0;
    int bad = 0;
    int words_seen = 0;
    int cur_scale, cur_shift, cur_zp;
    logic [8*LANES-1:0] last_data;
    logic [LANES-1:0]   last_keep;
    logic               last_last;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference requantization with plain 64-bit integer arithmetic.
    function automatic logic [7:0] model_q(int acc);
        longint p;
        longint v;
        p = longint'(acc) * longint'(cur_scale);
        if (cur_shift > 0) p = p + (longint'(1) <<< (cur_shift - 1));
        p = p >>> cur_shift;
`ifdef REQUANT_RELU_EN
        if (p < 0) p = 0;
`endif
        v = p + longint'(cur_zp);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic push_model(int acc, bit last);
        word_t w;
        pend.push_back(model_q(acc));
        if (pend.size() == LANES || last) begin
            w.data = '0;
            w.keep = '0;
            w.last = last;
            for (int i = 0; i < pend.size(); i++) begin
                w.data[8*i +: 8] = pend[i];
                w.keep[i] = 1'b1;
            end
            exp_q.push_back(w);
            pend.delete();
        end
    endtask

    task automatic set_cfg(int scale, int shift, int zp);
        cur_scale = scale;
        cur_shift = shift;
        cur_zp = zp;
        CFG_SCALE = 16'(scale);
        CFG_SHIFT = 5'(shift);
        CFG_ZERO_POINT = 8'(zp);
    endtask

    task automatic send(int acc, bit last);
        bit hs = 0;
        int n = 0;
        SD_AXIS_TDATA = acc;
        SD_AXIS_TLAST = last;
        SD_AXIS_TVALID = 1'b1;
        while (!hs && n < 300) begin
            @(negedge ACLK);
            hs = SD_AXIS_TREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        if (hs) push_model(acc, last);
        else check("send_timeout", 64'd0, 64'd1);
        SD_AXIS_TVALID = 1'b0;
        SD_AXIS_TLAST = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge ACLK);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard: a word counts as transferred when valid and ready are both high.
    always @(negedge ACLK) begin
        if (!ARESET && MO_AXIS_TVALID && MO_AXIS_TREADY) begin
            word_t w;
            words_seen++;
            last_data = MO_AXIS_TDATA;
            last_keep = MO_AXIS_TKEEP;
            last_last = MO_AXIS_TLAST;
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(MO_AXIS_TDATA), 64'hDEAD_0000_0000_0000);
            end else begin
                w = exp_q.pop_front();
                check("word_data", 64'(MO_AXIS_TDATA), 64'(w.data));
                check("word_keep", 64'(MO_AXIS_TKEEP), 64'(w.keep));
                check("word_last", 64'(MO_AXIS_TLAST), 64'(w.last));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bit done;
        logic [8*LANES-1:0] held;

        ARESET = 1'b1;
        SD_AXIS_TDATA = '0;
        SD_AXIS_TVALID = 1'b0;
        SD_AXIS_TLAST = 1'b0;
        MO_AXIS_TREADY = 1'b1;
        set_cfg(1, 0, 0);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_sd_ready", 64'(SD_AXIS_TREADY), 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("reset_tvalid", 64'(MO_AXIS_TVALID), 64'd0);
        check("reset_tdata", 64'(MO_AXIS_TDATA), 64'd0);
        check("reset_tkeep", 64'(MO_AXIS_TKEEP), 64'd0);
        check("reset_tlast", 64'(MO_AXIS_TLAST), 64'd0);
        check("post_reset_ready", 64'(SD_AXIS_TREADY), 64'd1);
        @(posedge ACLK);
        #1;

        // Basic pass-through with saturation and the latency of the completing element.
        set_cfg(1, 0, 0);
        send(5, 0);
        send(-3, 0);
        send(127, 0);
        send(200, 1);
        @(negedge ACLK);
        check("lat_edge_k", 64'(MO_AXIS_TVALID), 64'd0);
        @(negedge ACLK);
        check("lat_edge_k1", 64'(MO_AXIS_TVALID), 64'd0);
        @(negedge ACLK);
        check("lat_edge_k2", 64'(MO_AXIS_TVALID), 64'd1);
        drain();
        check("t1_data", 64'(last_data), 64'h7F7FFD05);
        check("t1_keep", 64'(last_keep), 64'hF);
        check("t1_last", 64'(last_last), 64'd1);

        // Rounding of positive and negative values.
        set_cfg(3, 2, 0);
        send(5, 0); send(-5, 0); send(6, 0); send(-6, 0);
        drain();
        check("t2_data", 64'(last_data), 64'hFC05FC04);

        // Zero point with an early TLAST, then a fresh full word.
        set_cfg(1, 0, 10);
        send(1, 0); send(2, 1);
        drain();
        check("t3_data", 64'(last_data), 64'h00000C0B);
        check("t3_keep", 64'(last_keep), 64'h3);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        drain();
        check("t3b_data", 64'(last_data), 64'h0E0D0C0B);
        check("t3b_keep", 64'(last_keep), 64'hF);

        // Consecutive TLAST elements produce separate one-lane words.
        set_cfg(1, 0, 0);
        send(9, 1); send(-9, 1);
        drain();
        check("tlast_pair_keep", 64'(last_keep), 64'h1);
        check("tlast_pair_data", 64'(last_data), 64'h000000F7);

        // Backpressure: the first word is held for five cycles.
        w0 = words_seen;
        MO_AXIS_TREADY = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(10 + i, 0);
            end
            begin
                int n = 0;
                while (!MO_AXIS_TVALID && n < 200) begin
                    @(negedge ACLK);
                    n++;
                end
                held = MO_AXIS_TDATA;
                for (int i = 0; i < 5; i++) begin
                    @(negedge ACLK);
                    check("bp_hold", 64'(MO_AXIS_TDATA), 64'(held));
                    check("bp_sd_ready", 64'(SD_AXIS_TREADY), 64'd0);
                end
                @(posedge ACLK);
                #1;
                MO_AXIS_TREADY = 1'b1;
            end
        join
        drain();
        check("bp_word_count", 64'(words_seen - w0), 64'd2);
        check("bp_second", 64'(last_data), 64'h11100F0E);

        // Reset in the middle of a word discards it.
        w0 = words_seen;
        send(7, 0);
        send(8, 0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid_reset_sd_ready", 64'(SD_AXIS_TREADY), 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        pend.delete();
        repeat (5) @(posedge ACLK);
        #1;
        check("mid_reset_no_word", 64'(words_seen - w0), 64'd0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        drain();
        check("mid_reset_fresh", 64'(last_data), 64'h04030201);

        // Negative zero point, saturation at both ends.
        set_cfg(1, 0, -5);
        send(-1000, 0); send(-3, 0); send(0, 0); send(50000, 0);
        drain();
`ifdef REQUANT_RELU_EN
        check("t6_data", 64'(last_data), 64'h7FFBFBFB);
`else
        check("t6_data", 64'(last_data), 64'h7FFBF880);
`endif

        // Randomized batches with random downstream backpressure.
        for (int b = 0; b < 5; b++) begin
            case (b)
                0: set_cfg(0, $urandom_range(0, 31), $urandom_range(0, 255) - 128);
                1: set_cfg($urandom_range(0, 65535), 31, $urandom_range(0, 255) - 128);
                default: set_cfg($urandom_range(0, 65535), $urandom_range(0, 31),
                                 $urandom_range(0, 255) - 128);
            endcase
            done = 0;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        int a;
                        a = (b == 4) ? ($urandom_range(0, 2000) - 1000) : int'($urandom);
                        send(a, (i == 39) || ($urandom_range(0, 5) == 0));
                    end
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge ACLK);
                        #1;
                        MO_AXIS_TREADY = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            MO_AXIS_TREADY = 1'b1;
            drain();
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
